// File: rtl/vga_pkg.sv
// Shared constants for the VGA draw path: default coordinate/colour widths,
// screen geometry and the draw-arbiter state encodings.
package vga_pkg;

    localparam int unsigned DEF_X_W  = 8;
    localparam int unsigned DEF_Y_W  = 7;
    localparam int unsigned DEF_C_W  = 9;
    localparam int unsigned SCREEN_W = 160;
    localparam int unsigned SCREEN_H = 120;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_ACK   = 2'd3;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin encoder: first set request at or above rr_ptr,
// wrapping around to bit 0.
module rr_priority_picker #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic               valid,
    output logic [IDX_W-1:0]   idx
);

    always_comb begin
        int unsigned cand;
        valid = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = 32'(rr_ptr) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/vga_draw_arbiter.sv
// Round-robin owner of the VGA framebuffer write port: runs one draw engine
// at a time, forwards its pixels one cycle late, then re-arms and acks it.
module vga_draw_arbiter
    import vga_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned X_W     = DEF_X_W,
    parameter int unsigned Y_W     = DEF_Y_W,
    parameter int unsigned C_W     = DEF_C_W,
    parameter int unsigned TIMEOUT = 32767
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    output logic [NUM_REQ-1:0]     ack,
    output logic [NUM_REQ-1:0]     eng_run,
    input  logic [NUM_REQ-1:0]     eng_done,
    input  logic [NUM_REQ-1:0]     eng_plot,
    input  logic [NUM_REQ*X_W-1:0] eng_x,
    input  logic [NUM_REQ*Y_W-1:0] eng_y,
    input  logic [NUM_REQ*C_W-1:0] eng_colour,
    output logic [X_W-1:0]         vga_x,
    output logic [Y_W-1:0]         vga_y,
    output logic [C_W-1:0]         vga_colour,
    output logic                   vga_plot,
    output logic                   busy,
    output logic                   timeout_err
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

    logic [1:0]         state, state_n;
    logic [IDX_W-1:0]   grant, grant_n;
    logic [IDX_W-1:0]   rr_ptr, rr_ptr_n;
    logic [TMR_W-1:0]   timer, timer_n;
    logic [NUM_REQ-1:0] eng_run_n, ack_n;
    logic [X_W-1:0]     vga_x_n;
    logic [Y_W-1:0]     vga_y_n;
    logic [C_W-1:0]     vga_colour_n;
    logic               vga_plot_n, busy_n, timeout_err_n;

    logic               pick_valid;
    logic [IDX_W-1:0]   pick_idx;

    logic [X_W-1:0]     sel_x;
    logic [Y_W-1:0]     sel_y;
    logic [C_W-1:0]     sel_colour;
    logic               sel_plot, sel_done;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req    (req),
        .rr_ptr (rr_ptr),
        .valid  (pick_valid),
        .idx    (pick_idx)
    );

    // Granted engine's pixel stream; all other engines are ignored.
    always_comb begin
        sel_x      = '0;
        sel_y      = '0;
        sel_colour = '0;
        sel_plot   = 1'b0;
        sel_done   = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant == IDX_W'(i)) begin
                sel_x      = eng_x[i*X_W +: X_W];
                sel_y      = eng_y[i*Y_W +: Y_W];
                sel_colour = eng_colour[i*C_W +: C_W];
                sel_plot   = eng_plot[i];
                sel_done   = eng_done[i];
            end
        end
    end

    always_comb begin
        state_n       = state;
        grant_n       = grant;
        rr_ptr_n      = rr_ptr;
        timer_n       = timer;
        eng_run_n     = eng_run;
        ack_n         = '0;
        vga_x_n       = vga_x;
        vga_y_n       = vga_y;
        vga_colour_n  = vga_colour;
        vga_plot_n    = 1'b0;
        timeout_err_n = timeout_err;

        case (state)
            ST_IDLE: begin
                if (pick_valid) begin
                    grant_n   = pick_idx;
                    timer_n   = '0;
                    eng_run_n = NUM_REQ'(1) << pick_idx;
                    state_n   = ST_RUN;
                end
            end
            ST_RUN: begin
                vga_x_n      = sel_x;
                vga_y_n      = sel_y;
                vga_colour_n = sel_colour;
                vga_plot_n   = sel_plot & ~sel_done;
                timer_n      = timer + TMR_W'(1);
                if (sel_done) begin
                    vga_plot_n = 1'b0;
                    eng_run_n  = '0;
                    state_n    = ST_DRAIN;
                end else if (timer == TMR_W'(TIMEOUT - 1)) begin
                    // Forced release: the stuck engine's final pixel is dropped.
                    vga_plot_n    = 1'b0;
                    eng_run_n     = '0;
                    timeout_err_n = 1'b1;
                    state_n       = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                ack_n   = NUM_REQ'(1) << grant;
                state_n = ST_ACK;
            end
            ST_ACK: begin
                rr_ptr_n = (grant == IDX_W'(NUM_REQ - 1)) ? '0 : grant + IDX_W'(1);
                state_n  = ST_IDLE;
            end
            default: begin
                eng_run_n = '0;
                state_n   = ST_IDLE;
            end
        endcase

        busy_n = (state_n != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            grant       <= '0;
            rr_ptr      <= '0;
            timer       <= '0;
            eng_run     <= '0;
            ack         <= '0;
            vga_x       <= '0;
            vga_y       <= '0;
            vga_colour  <= '0;
            vga_plot    <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_n;
            grant       <= grant_n;
            rr_ptr      <= rr_ptr_n;
            timer       <= timer_n;
            eng_run     <= eng_run_n;
            ack         <= ack_n;
            vga_x       <= vga_x_n;
            vga_y       <= vga_y_n;
            vga_colour  <= vga_colour_n;
            vga_plot    <= vga_plot_n;
            busy        <= busy_n;
            timeout_err <= timeout_err_n;
        end
    end

endmodule

// File: tb/tb_vga_draw_arbiter.sv
// Directed bench for vga_draw_arbiter: behavioural raster engines feed the
// main instance; a second instance with TIMEOUT=100 exercises forced release.
module tb_vga_draw_arbiter;
    import vga_pkg::*;

    localparam int unsigned N   = 4;
    localparam int unsigned XW  = DEF_X_W;
    localparam int unsigned YW  = DEF_Y_W;
    localparam int unsigned CW  = DEF_C_W;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N-1:0]    ack, eng_run, eng_done, eng_plot;
    logic [N*XW-1:0] eng_x;
    logic [N*YW-1:0] eng_y;
    logic [N*CW-1:0] eng_colour;
    logic [XW-1:0]   vga_x;
    logic [YW-1:0]   vga_y;
    logic [CW-1:0]   vga_colour;
    logic            vga_plot, busy, timeout_err;

    logic [N-1:0]    t_req = '0;
    logic [N-1:0]    t_ack, t_run;
    logic [N-1:0]    t_done = '0;
    logic [N*XW-1:0] t_x = '0;
    logic [N*YW-1:0] t_y = '0;
    logic [N*CW-1:0] t_colour = '0;
    logic [XW-1:0]   t_vga_x;
    logic [YW-1:0]   t_vga_y;
    logic [CW-1:0]   t_vga_colour;
    logic            t_vga_plot, t_busy, t_timeout_err;

    always #5 clk = ~clk;

    vga_draw_arbiter dut (
        .clk(clk), .reset(reset), .req(req), .ack(ack), .eng_run(eng_run),
        .eng_done(eng_done), .eng_plot(eng_plot), .eng_x(eng_x), .eng_y(eng_y),
        .eng_colour(eng_colour), .vga_x(vga_x), .vga_y(vga_y),
        .vga_colour(vga_colour), .vga_plot(vga_plot), .busy(busy),
        .timeout_err(timeout_err)
    );

    vga_draw_arbiter #(.TIMEOUT(100)) dut_t (
        .clk(clk), .reset(reset), .req(t_req), .ack(t_ack), .eng_run(t_run),
        .eng_done(t_done), .eng_plot(t_run), .eng_x(t_x), .eng_y(t_y),
        .eng_colour(t_colour), .vga_x(t_vga_x), .vga_y(t_vga_y),
        .vga_colour(t_vga_colour), .vga_plot(t_vga_plot), .busy(t_busy),
        .timeout_err(t_timeout_err)
    );

    // Engine models: raster counter held at 0 while not running, sticky done at eng_len.
    int          eng_len [N];
    logic [15:0] cnt [N];

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (!eng_run[i]) cnt[i] <= '0;
            else if (!eng_done[i]) cnt[i] <= cnt[i] + 16'd1;
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            eng_done[i] = eng_run[i] && (int'(cnt[i]) >= eng_len[i]);
            eng_plot[i] = eng_run[i] && !eng_done[i];
            eng_x[i*XW +: XW]      = XW'(int'(cnt[i]) % SCREEN_W);
            eng_y[i*YW +: YW]      = YW'(int'(cnt[i]) / SCREEN_W);
            eng_colour[i*CW +: CW] = CW'(i * 37 + int'(cnt[i]));
        end
    end

    // Monitor of the main instance, sampled on the falling edge.
    int cyc = 0, idx = 0, plot_total = 0, pix_err = 0, onehot_err = 0, plot_bad = 0;
    int ack_total = 0, run_rise_cyc = -1, first_plot_cyc = -1, done_cyc = -1, ack_cyc = -1;
    int cur_g = 0;
    int grant_log[$];
    int ack_log[$];
    logic [N-1:0] prev_run = '0;

    always @(negedge clk) begin
        cyc++;
        if (!$onehot0(eng_run) || !$onehot0(ack)) onehot_err++;
        if (eng_run != '0 && prev_run == '0) begin
            for (int i = 0; i < N; i++) if (eng_run[i]) cur_g = i;
            grant_log.push_back(cur_g);
            run_rise_cyc = cyc;
            first_plot_cyc = -1;
            done_cyc = -1;
            idx = 0;
        end
        for (int i = 0; i < N; i++) begin
            if (ack[i]) begin
                ack_log.push_back(i);
                ack_total++;
                ack_cyc = cyc;
            end
        end
        if (eng_run != '0 && eng_done[cur_g] && done_cyc < 0) done_cyc = cyc;
        if (vga_plot) begin
            if (eng_run == '0) plot_bad++;
            else begin
                if (int'(vga_x) != idx % SCREEN_W || int'(vga_y) != idx / SCREEN_W ||
                    vga_colour != CW'(cur_g * 37 + idx)) pix_err++;
                if (first_plot_cyc < 0) first_plot_cyc = cyc;
                idx++;
                plot_total++;
            end
        end
        prev_run = eng_run;
    end

    int n_assert = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic serve_all(input int budget);
        int n;
        n = 0;
        while (req != '0 && n < budget) begin
            tick();
            req = req & ~ack;
            n++;
        end
        check("serve_done", 32'(req == '0), 1);
        tick();
        tick();
    endtask

    int base, p0, a0, run_cnt, t_acks, n;

    initial begin
        for (int i = 0; i < N; i++) eng_len[i] = 10;
        repeat (3) tick();
        check("rst_eng_run", 32'(eng_run), 0);
        check("rst_ack", 32'(ack), 0);
        check("rst_plot", 32'(vga_plot), 0);
        check("rst_x", 32'(vga_x), 0);
        check("rst_y", 32'(vga_y), 0);
        check("rst_colour", 32'(vga_colour), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_terr", 32'(timeout_err), 0);
        reset = 1'b0;
        tick();

        // All four at once: 0,1,2,3 from a fresh pointer.
        base = grant_log.size();
        p0 = plot_total;
        req = 4'b1111;
        serve_all(400);
        for (int k = 0; k < 4; k++) begin
            check("rr_grant", 32'(grant_log[base + k]), 32'(k));
            check("rr_ack", 32'(ack_log[base + k]), 32'(k));
        end
        check("rr_plots", 32'(plot_total - p0), 40);

        // Serve 2, then 0101 wraps to 0 before 2.
        base = grant_log.size();
        req = 4'b0100;
        serve_all(100);
        req = 4'b0101;
        serve_all(200);
        check("wrap_g0", 32'(grant_log[base]), 2);
        check("wrap_g1", 32'(grant_log[base + 1]), 0);
        check("wrap_g2", 32'(grant_log[base + 2]), 2);

        // Full screen on engine 1.
        eng_len[1] = SCREEN_W * SCREEN_H;
        p0 = plot_total;
        a0 = ack_total;
        req = 4'b0010;
        serve_all(20000);
        check("full_plots", 32'(plot_total - p0), 19200);
        check("full_last_idx", 32'(idx), 19200);
        check("full_grant", 32'(grant_log[grant_log.size() - 1]), 1);
        check("full_latency", 32'(first_plot_cyc - run_rise_cyc), 1);
        check("full_ack_gap", 32'(ack_cyc - done_cyc), 2);
        check("full_ack_count", 32'(ack_total - a0), 1);

        // Done already high at grant.
        eng_len[2] = 0;
        p0 = plot_total;
        req = 4'b0100;
        serve_all(50);
        check("pre_done_plots", 32'(plot_total - p0), 0);
        check("pre_done_seen", 32'(done_cyc - run_rise_cyc), 0);
        check("pre_done_ack", 32'(ack_cyc - run_rise_cyc), 2);

        // Stuck engine 3 on the TIMEOUT=100 instance.
        check("to_terr_before", 32'(t_timeout_err), 0);
        t_req = 4'b1000;
        run_cnt = 0;
        t_acks = 0;
        n = 0;
        while (t_acks == 0 && n < 400) begin
            tick();
            if (t_run[3]) run_cnt++;
            if (t_run[2:0] != '0) run_cnt += 1000;
            if (t_ack[3]) begin
                t_acks++;
                t_req = '0;
            end
            n++;
        end
        tick();
        check("to_acked", 32'(t_acks), 1);
        check("to_run_cycles", 32'(run_cnt), 100);
        check("to_terr", 32'(t_timeout_err), 1);
        check("to_run_drop", 32'(t_run), 0);
        check("to_ack_clear", 32'(t_ack), 0);

        // Reset at pixel 5000 of a full-screen draw.
        eng_len[1] = SCREEN_W * SCREEN_H;
        req = 4'b0010;
        n = 0;
        while (idx < 5000 && n < 6000) begin
            tick();
            n++;
        end
        check("mid_reached", 32'(idx), 5000);
        check("mid_busy", 32'(busy), 1);
        a0 = ack_total;
        reset = 1'b1;
        tick();
        check("mr_eng_run", 32'(eng_run), 0);
        check("mr_ack", 32'(ack), 0);
        check("mr_plot", 32'(vga_plot), 0);
        check("mr_x", 32'(vga_x), 0);
        check("mr_y", 32'(vga_y), 0);
        check("mr_colour", 32'(vga_colour), 0);
        check("mr_busy", 32'(busy), 0);
        check("mr_terr_cleared", 32'(t_timeout_err), 0);
        reset = 1'b0;
        n = 0;
        while (!vga_plot && n < 10) begin
            tick();
            n++;
        end
        check("restart_plot", 32'(vga_plot), 1);
        check("restart_x", 32'(vga_x), 0);
        check("restart_y", 32'(vga_y), 0);
        check("restart_no_ack", 32'(ack_total - a0), 0);
        eng_len[1] = 20;
        serve_all(100);
        check("restart_ack", 32'(ack_total - a0), 1);

        check("pixel_errors", 32'(pix_err), 0);
        check("onehot_errors", 32'(onehot_err), 0);
        check("plot_outside_run", 32'(plot_bad), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_draw_arbiter.md
Name: vga_draw_arbiter

Overview:
- Shares the single VGA framebuffer write port among up to NUM_REQ full-screen/sprite draw engines.
- Each engine streams x/y/colour pixels and raises a sticky done flag.
- The arbiter grants one engine at a time (round-robin), runs it, forwards its pixels to the VGA adapter, detects done, re-arms the engine and acknowledges the requester.
- It sits between the game FSM (requesters) and the VGA adapter input.

Parameters:
- NUM_REQ, 4, number of draw engines/requesters.
- X_W, 8, x coordinate width (160 columns).
- Y_W, 7, y coordinate width (120 rows).
- C_W, 9, colour width (3 bits per channel).
- TIMEOUT, 32767, max cycles a grant may last before forced release (must exceed 19200+2).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  level request per engine; held until matching ack.
- ack  out  NUM_REQ  one-cycle pulse when that engine's draw completes or times out.
- eng_run  out  NUM_REQ  one-hot; engine i runs when its bit is 1, held in reset (its active-low reset driven by eng_run[i]) when 0.
- eng_done  in  NUM_REQ  sticky done from each engine.
- eng_plot  in  NUM_REQ  pixel-valid from each engine; engines without one tie it to eng_run & ~eng_done.
- eng_x  in  NUM_REQ*X_W  packed x, engine i at [i*X_W +: X_W].
- eng_y  in  NUM_REQ*Y_W  packed y.
- eng_colour  in  NUM_REQ*C_W  packed colour.
- vga_x  out  X_W  registered x to VGA.
- vga_y  out  Y_W  registered y.
- vga_colour  out  C_W  registered colour.
- vga_plot  out  1  registered write enable.
- busy  out  1  high in any state except IDLE.
- timeout_err  out  1  sticky; set on forced release, cleared only by reset.

Behaviour:
- Reset (sync, high): state IDLE, eng_run=0, ack=0, vga_plot=0, vga_x/y/colour=0, busy=0, timeout_err=0, rr_ptr=0 (engine 0 has top priority first), timer=0.
- States: IDLE, RUN, DRAIN, ACK.
- IDLE:
  - If any req, select the first set bit scanning from rr_ptr upward with wrap; latch grant index g.
  - Next cycle: RUN, eng_run[g]=1, timer=0.
  - Arbitration decision takes 1 cycle; with no req, stay in IDLE.
- RUN:
  - vga_x/y/colour <= engine g's fields every cycle.
  - vga_plot <= eng_plot[g] & ~eng_done[g].
  - Pixel latency is 1 cycle, input to VGA output.
  - timer increments.
  - If eng_done[g]: go to DRAIN, vga_plot <= 0.
  - Else if timer == TIMEOUT-1: go to DRAIN and set timeout_err.
- DRAIN: one cycle; eng_run[g]=0 (re-arms the engine; its done clears under its own reset); vga_plot=0. Go to ACK.
- ACK: ack[g]=1 for exactly this cycle; rr_ptr <= (g+1) mod NUM_REQ; go to IDLE.
- Minimum grant-to-grant gap: 3 cycles after done (DRAIN, ACK, IDLE).
- req dropped mid-RUN: ignored. The draw completes and is still acked.
- Requester must deassert req the cycle after ack; a req still high in IDLE is treated as a new request.
- eng_done[g] already high on RUN entry: zero pixels plotted, normal DRAIN/ACK.
- Non-granted engines' plot/done/pixel inputs are ignored.
- vga_plot is never high outside RUN+1 cycle; only one eng_run bit is ever high.
- Reset mid-RUN: everything returns to reset values next cycle, no ack issued, engine held in reset.

Decomposition:
- Shared package (vga_pkg): X_W/Y_W/C_W defaults; SCREEN_W=160, SCREEN_H=120; state encodings (IDLE=2'd0, RUN=2'd1, DRAIN=2'd2, ACK=2'd3).
- One sub-module: rr_priority_picker. Combinational round-robin encoder taking req and rr_ptr, producing valid and grant index.
- Pixel mux and FSM live in the top module.

Test Plan:
- Single request, engine 1 model plots 160x120 then done:
  - exactly 19200 vga_plot cycles with x 0..159, y 0..119 in raster order, each 1 cycle after the engine output;
  - ack[1] one pulse, 2 cycles after done seen.
- req=4'b1111 at the same time, each engine 10-pixel draw: grant order 0,1,2,3; only one eng_run bit high at any time; no vga_plot during DRAIN/ACK.
- After serving 2, hold req=4'b0101: next grant is engine 0 (wrap from rr_ptr=3), then 2.
- Engine 3 never asserts done, TIMEOUT=100: forced release after 100 RUN cycles, timeout_err=1, ack[3] pulses, eng_run[3] drops.
- Reset asserted at pixel 5000 of a grant: next cycle all outputs 0 and state IDLE; no ack; re-request restarts at pixel (0,0).
- Engine with done already high at grant: vga_plot never asserts; ack within 3 cycles of RUN entry.
